sm3_msg_byte_pckr: RTL and testbench

Upstream feeder for sm3_core_top. It accepts an arbitrary-length message as a byte stream with a valid/ready/last handshake and packs it MSB-first into INPT_DW-bit words. It drives the core's message input bus: msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld and msg_inpt_lst, honouring msg_inpt_rdy. Non-aligned tails are zero-filled with a contiguous MSB-first byte-valid mask.

---
 rtl/sm3_msg_byte_pckr_pkg.sv | 35 +++
 rtl/sm3_msg_byte_pckr_if.sv | 30 +++
 rtl/sm3_msg_byte_pckr_word_out_reg.sv | 57 +++++
 rtl/sm3_msg_byte_pckr.sv | 117 +++++++++++
 tb/tb_sm3_msg_byte_pckr.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_msg_byte_pckr_pkg.sv
// Shared types and helpers for the SM3 message byte packer: accumulator states,
// MSB-first byte-valid masks and zero-filling of unused lanes.
package sm3_pckr_pkg;

   localparam int INPT_DW_DEF  = 32;
   localparam int MAX_DW       = 64;
   localparam int MAX_BYTE_NUM = MAX_DW / 8;

   typedef enum logic {
      ACC_FILL = 1'b0,
      ACC_DONE = 1'b1
   } acc_state_e;

   // Ones over lanes 0..idx, where lane 0 is the most significant byte of a
   // byte_num-lane word; right-justified in the returned vector.
   function automatic logic [MAX_BYTE_NUM-1:0] vld_byte_mask(input int idx, input int byte_num);
      logic [MAX_BYTE_NUM-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_BYTE_NUM; i++) begin
         if (i < byte_num && i <= idx) m[3'(byte_num - 1 - i)] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [MAX_DW-1:0] lane_zero_fill(input logic [MAX_DW-1:0] d, input int idx,
                                                        input int byte_num);
      logic [MAX_DW-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_BYTE_NUM; i++) begin
         if (i < byte_num && i <= idx) r[6'(8 * (byte_num - 1 - i)) +: 8] = d[6'(8 * (byte_num - 1 - i)) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/sm3_msg_byte_pckr_if.sv
// Byte-stream input and SM3 core message-word output of the packer.
// master = byte source / word sink side, slave = the packer itself.
interface sm3_msg_byte_pckr_if
   import sm3_pckr_pkg::*;
#(
   parameter int INPT_DW = INPT_DW_DEF
);
   localparam int BYTE_NUM = INPT_DW / 8;

   logic [7:0]          byte_d;
   logic                byte_vld;
   logic                byte_lst;
   logic                byte_rdy;
   logic [INPT_DW-1:0]  msg_inpt_d;
   logic [BYTE_NUM-1:0] msg_inpt_vld_byte;
   logic                msg_inpt_vld;
   logic                msg_inpt_lst;
   logic                msg_inpt_rdy;

   modport master (
      output byte_d, byte_vld, byte_lst, msg_inpt_rdy,
      input  byte_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
   );

   modport slave (
      input  byte_d, byte_vld, byte_lst, msg_inpt_rdy,
      output byte_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst
   );

endinterface

// File: rtl/sm3_msg_byte_pckr_word_out_reg.sv
// One-entry output holding register for packed message words: contents stay
// stable while the core stalls, and the byte mask and lst read 0 whenever empty.
module sm3_word_out_reg
   import sm3_pckr_pkg::*;
#(
   parameter int  INPT_DW  = INPT_DW_DEF,
   localparam int BYTE_NUM = INPT_DW / 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [INPT_DW-1:0]  i_d,
   input  logic [BYTE_NUM-1:0] i_vld_byte,
   input  logic                i_lst,
   input  logic                i_rdy,
   output logic                o_vld,
   output logic [INPT_DW-1:0]  o_d,
   output logic [BYTE_NUM-1:0] o_vld_byte,
   output logic                o_lst,
   output logic                o_free
);

   logic                r_vld;
   logic [INPT_DW-1:0]  r_d;
   logic [BYTE_NUM-1:0] r_vld_byte;
   logic                r_lst;
   logic                w_xfer;

   assign w_xfer = r_vld && i_rdy;
   assign o_free = !r_vld || i_rdy;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values of its neighbours regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld      <= 1'b0;
         r_d        <= '0;
         r_vld_byte <= '0;
         r_lst      <= 1'b0;
      end else if (i_load) begin
         r_vld      <= 1'b1;
         r_d        <= i_d;
         r_vld_byte <= i_vld_byte;
         r_lst      <= i_lst;
      end else if (w_xfer) begin
         r_vld      <= 1'b0;
         r_vld_byte <= '0;
         r_lst      <= 1'b0;
      end
   end

   assign o_vld      = r_vld;
   assign o_d        = r_d;
   assign o_vld_byte = r_vld_byte;
   assign o_lst      = r_lst;

endmodule

// File: rtl/sm3_msg_byte_pckr.sv
// Packs a byte stream MSB-first into INPT_DW-bit words for the SM3 core, zero-filling
// short tails; an accumulator feeds a one-entry output register.
module sm3_msg_byte_pckr
   import sm3_pckr_pkg::*;
#(
   parameter int INPT_DW = INPT_DW_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   sm3_msg_byte_pckr_if.slave      bus,
   output logic [60:0]             sts_byte_cnt,
   output logic [15:0]             sts_msg_cnt
);

   localparam int                BYTE_NUM  = INPT_DW / 8;
   localparam int                IDX_W     = $clog2(BYTE_NUM);
   localparam logic [IDX_W-1:0]  LAST_LANE = IDX_W'(BYTE_NUM - 1);

   acc_state_e          r_state, w_state_nxt;
   logic [INPT_DW-1:0]  r_acc_d, w_acc_d_base, w_acc_d_nxt;
   logic [IDX_W-1:0]    r_acc_idx, w_acc_idx_base, w_acc_idx_nxt;
   logic                r_acc_lst, w_acc_lst_nxt;
   logic [60:0]         r_byte_cnt;
   logic [15:0]         r_msg_cnt;

   logic                w_acc_move;
   logic                w_out_free;
   logic                w_byte_xfer;
   logic                w_lst_xfer;
   logic [INPT_DW-1:0]  w_out_d;
   logic [BYTE_NUM-1:0] w_out_mask;

   // byte_rdy is combinational from msg_inpt_rdy: a completed word can leave and a
   // new byte can enter lane 0 in the same cycle, which sustains full throughput.
   assign w_acc_move   = (r_state == ACC_DONE) && w_out_free;
   assign bus.byte_rdy = !rst && ((r_state == ACC_FILL) || w_acc_move);
   assign w_byte_xfer  = bus.byte_vld && bus.byte_rdy;
   assign w_lst_xfer   = bus.msg_inpt_vld && bus.msg_inpt_rdy && bus.msg_inpt_lst;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_acc_d_base   = r_acc_d;
      w_acc_idx_base = r_acc_idx;
      w_acc_lst_nxt  = r_acc_lst;
      if (w_acc_move) begin
         w_state_nxt    = ACC_FILL;
         w_acc_d_base   = '0;
         w_acc_idx_base = '0;
         w_acc_lst_nxt  = 1'b0;
      end
      w_acc_d_nxt   = w_acc_d_base;
      w_acc_idx_nxt = w_acc_idx_base;
      if (w_byte_xfer) begin
         for (int i = 0; i < BYTE_NUM; i++) begin
            if (w_acc_idx_base == IDX_W'(i)) w_acc_d_nxt[INPT_DW - 8 - 8 * i +: 8] = bus.byte_d;
         end
         // In DONE the index keeps the last filled lane so the mask can be derived.
         if (bus.byte_lst || w_acc_idx_base == LAST_LANE) begin
            w_state_nxt   = ACC_DONE;
            w_acc_lst_nxt = bus.byte_lst;
         end else begin
            w_acc_idx_nxt = w_acc_idx_base + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ACC_FILL;
         r_acc_d   <= '0;
         r_acc_idx <= '0;
         r_acc_lst <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc_d   <= w_acc_d_nxt;
         r_acc_idx <= w_acc_idx_nxt;
         r_acc_lst <= w_acc_lst_nxt;
      end
   end

   assign w_out_mask = BYTE_NUM'(vld_byte_mask(int'(r_acc_idx), BYTE_NUM));
   assign w_out_d    = INPT_DW'(lane_zero_fill(MAX_DW'(r_acc_d), int'(r_acc_idx), BYTE_NUM));

   sm3_word_out_reg #(
      .INPT_DW (INPT_DW)
   ) u_word_out_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_acc_move),
      .i_d        (w_out_d),
      .i_vld_byte (w_out_mask),
      .i_lst      (r_acc_lst),
      .i_rdy      (bus.msg_inpt_rdy),
      .o_vld      (bus.msg_inpt_vld),
      .o_d        (bus.msg_inpt_d),
      .o_vld_byte (bus.msg_inpt_vld_byte),
      .o_lst      (bus.msg_inpt_lst),
      .o_free     (w_out_free)
   );

   // A byte accepted in the same cycle as the final word leaves belongs to the next message.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_byte_cnt <= '0;
         r_msg_cnt  <= '0;
      end else begin
         if (w_lst_xfer) r_byte_cnt <= w_byte_xfer ? 61'd1 : 61'd0;
         else if (w_byte_xfer) r_byte_cnt <= r_byte_cnt + 61'd1;
         if (w_lst_xfer) r_msg_cnt <= r_msg_cnt + 16'd1;
      end
   end

   assign sts_byte_cnt = r_byte_cnt;
   assign sts_msg_cnt  = r_msg_cnt;

endmodule

// File: tb/tb_sm3_msg_byte_pckr.sv
// Bench for sm3_msg_byte_pckr: 32- and 64-bit instances, expected words derived by
// chunking each message into big-endian words with a queue-based reference model.
module tb_sm3_msg_byte_pckr;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sm3_msg_byte_pckr_if #(.INPT_DW(32)) bus32 ();
   sm3_msg_byte_pckr_if #(.INPT_DW(64)) bus64 ();

   logic [60:0] byte_cnt32, byte_cnt64;
   logic [15:0] msg_cnt32, msg_cnt64;

   sm3_msg_byte_pckr #(.INPT_DW(32)) dut32 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus32),
      .sts_byte_cnt (byte_cnt32),
      .sts_msg_cnt  (msg_cnt32)
   );

   sm3_msg_byte_pckr #(.INPT_DW(64)) dut64 (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus64),
      .sts_byte_cnt (byte_cnt64),
      .sts_msg_cnt  (msg_cnt64)
   );

   int n_cmp = 0;
   int n_err = 0;
   bit rdy_rand = 1'b0;

   logic [7:0]  msg_bytes[$];
   logic [63:0] exp_d[$], obs_d[$];
   logic [7:0]  exp_m[$], obs_m[$];
   bit          exp_l[$], obs_l[$];
   int          exp_msg[2];

   // Word monitor: a transfer happens at the next rising edge iff vld && rdy here.
   always @(negedge clk) begin
      if (!rst && bus32.msg_inpt_vld && bus32.msg_inpt_rdy) begin
         obs_d.push_back(64'(bus32.msg_inpt_d));
         obs_m.push_back(8'(bus32.msg_inpt_vld_byte));
         obs_l.push_back(bus32.msg_inpt_lst);
      end
      if (!rst && bus64.msg_inpt_vld && bus64.msg_inpt_rdy) begin
         obs_d.push_back(bus64.msg_inpt_d);
         obs_m.push_back(bus64.msg_inpt_vld_byte);
         obs_l.push_back(bus64.msg_inpt_lst);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_rand) begin
         bus32.msg_inpt_rdy = 1'($urandom_range(0, 1));
         bus64.msg_inpt_rdy = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_sb();
      exp_d.delete(); exp_m.delete(); exp_l.delete();
      obs_d.delete(); obs_m.delete(); obs_l.delete();
   endtask

   // Reference model: split msg_bytes into bn-byte chunks, first byte most significant.
   task automatic model_msg(input int bn);
      int n;
      n = msg_bytes.size();
      for (int i = 0; i < n; i += bn) begin
         logic [63:0] w = '0;
         logic [7:0]  m = '0;
         for (int j = 0; j < bn; j++) begin
            if (i + j < n) begin
               w[8 * (bn - 1 - j) +: 8] = msg_bytes[i + j];
               m[bn - 1 - j] = 1'b1;
            end
         end
         exp_d.push_back(w);
         exp_m.push_back(m);
         exp_l.push_back(i + bn >= n);
      end
   endtask

   task automatic drive(input bit w64, input bit v, input logic [7:0] d, input bit l);
      if (w64) begin
         bus64.byte_vld = v; bus64.byte_d = d; bus64.byte_lst = l;
      end else begin
         bus32.byte_vld = v; bus32.byte_d = d; bus32.byte_lst = l;
      end
   endtask

   function automatic bit rdy_of(input bit w64);
      return w64 ? bus64.byte_rdy : bus32.byte_rdy;
   endfunction

   // Send msg_bytes[lo..hi-1]; idle gaps carry a random byte_lst with byte_vld=0.
   task automatic send(input bit w64, input int lo, input int hi, input bit lst_end, input int gap_max);
      int  gap;
      int  wait_cyc;
      bit  acc;
      for (int i = lo; i < hi; i++) begin
         gap = int'($urandom_range(0, gap_max));
         for (int g = 0; g < gap; g++) begin
            drive(w64, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            @(posedge clk); #1;
         end
         drive(w64, 1'b1, msg_bytes[i], lst_end && (i == hi - 1));
         acc = 1'b0;
         wait_cyc = 0;
         while (!acc && wait_cyc < 200) begin
            @(negedge clk);
            acc = rdy_of(w64);
            @(posedge clk); #1;
            wait_cyc++;
         end
         if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout byte %0d: byte_rdy stayed 0, required 1 within 200 cycles", i);
         end
      end
      drive(w64, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic drain_and_compare(input bit w64, input string tag);
      int w = 0;
      while (obs_d.size() < exp_d.size() && w < 2000) begin
         @(posedge clk);
         w++;
      end
      repeat (8) @(posedge clk);
      #1;
      n_cmp++;
      if (obs_d.size() != exp_d.size()) begin
         n_err++;
         $display("FAIL %s word_count: got %0d words, required %0d", tag, obs_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
         n_cmp++;
         if ({obs_d[i], obs_m[i], obs_l[i]} !== {exp_d[i], exp_m[i], exp_l[i]}) begin
            n_err++;
            $display("FAIL %s word %0d: got d=%h mask=%b lst=%b, required d=%h mask=%b lst=%b",
                     tag, i, obs_d[i], obs_m[i], obs_l[i], exp_d[i], exp_m[i], exp_l[i]);
         end
      end
      n_cmp++;
      if ((w64 ? msg_cnt64 : msg_cnt32) !== 16'(exp_msg[w64])) begin
         n_err++;
         $display("FAIL %s sts_msg_cnt: got %0d, required %0d", tag, w64 ? msg_cnt64 : msg_cnt32, exp_msg[w64]);
      end
      n_cmp++;
      if ((w64 ? byte_cnt64 : byte_cnt32) !== 61'd0) begin
         n_err++;
         $display("FAIL %s sts_byte_cnt: got %0d, required 0", tag, w64 ? byte_cnt64 : byte_cnt32);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b1, 8'h5A, 1'b0);
      drive(1'b1, 1'b1, 8'h5A, 1'b0);
      bus32.msg_inpt_rdy = 1'b1;
      bus64.msg_inpt_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus32.byte_rdy, bus32.msg_inpt_vld, bus32.msg_inpt_lst, bus32.msg_inpt_vld_byte, bus32.msg_inpt_d} !== '0) begin
         n_err++;
         $display("FAIL reset_out32: got rdy=%b vld=%b lst=%b mask=%b d=%h, required all 0", bus32.byte_rdy,
                  bus32.msg_inpt_vld, bus32.msg_inpt_lst, bus32.msg_inpt_vld_byte, bus32.msg_inpt_d);
      end
      n_cmp++;
      if ({bus64.byte_rdy, bus64.msg_inpt_vld, bus64.msg_inpt_lst, bus64.msg_inpt_vld_byte, bus64.msg_inpt_d} !== '0) begin
         n_err++;
         $display("FAIL reset_out64: got rdy=%b vld=%b lst=%b mask=%b d=%h, required all 0", bus64.byte_rdy,
                  bus64.msg_inpt_vld, bus64.msg_inpt_lst, bus64.msg_inpt_vld_byte, bus64.msg_inpt_d);
      end
      n_cmp++;
      if ({byte_cnt32, msg_cnt32, byte_cnt64, msg_cnt64} !== '0) begin
         n_err++;
         $display("FAIL reset_cnt: got %0d %0d %0d %0d, required all 0", byte_cnt32, msg_cnt32, byte_cnt64, msg_cnt64);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus32.byte_rdy, bus64.byte_rdy} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_release byte_rdy: got %b%b, required 11", bus32.byte_rdy, bus64.byte_rdy);
      end
      @(posedge clk); #1;
      exp_msg[0] = 0;
      exp_msg[1] = 0;
   endtask

   task automatic test_abc();
      clear_sb();
      msg_bytes = '{8'h61, 8'h62, 8'h63};
      model_msg(4);
      exp_msg[0]++;
      send(1'b0, 0, 3, 1'b1, 0);
      drain_and_compare(1'b0, "abc");
      n_cmp++;
      if ({obs_d[0], obs_m[0]} !== {64'h0000_0000_6162_6300, 8'b0000_1110}) begin
         n_err++;
         $display("FAIL abc_literal: got d=%h mask=%b, required d=61626300 mask=1110", obs_d[0], obs_m[0]);
      end
   endtask

   task automatic test_64_bytes();
      time t0;
      clear_sb();
      msg_bytes.delete();
      for (int i = 0; i < 64; i++) msg_bytes.push_back(8'h61 + 8'(i % 4));
      model_msg(4);
      exp_msg[0]++;
      t0 = $time;
      send(1'b0, 0, 64, 1'b1, 0);
      n_cmp++;
      if (($time - t0) / 10 != 64) begin
         n_err++;
         $display("FAIL throughput: 64 bytes took %0d cycles, required 64", ($time - t0) / 10);
      end
      drain_and_compare(1'b0, "bytes64");
   endtask

   task automatic test_backpressure();
      clear_sb();
      msg_bytes.delete();
      for (int i = 0; i < 12; i++) msg_bytes.push_back(8'($urandom));
      model_msg(4);
      exp_msg[0]++;
      bus32.msg_inpt_rdy = 1'b0;
      fork
         send(1'b0, 0, 12, 1'b1, 0);
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (c >= 10) begin
                  n_cmp++;
                  if (bus32.msg_inpt_vld !== 1'b1 || 64'(bus32.msg_inpt_d) !== exp_d[0] ||
                      8'(bus32.msg_inpt_vld_byte) !== exp_m[0] || bus32.byte_rdy !== 1'b0) begin
                     n_err++;
                     $display("FAIL bp_stall cycle %0d: got vld=%b d=%h mask=%b byte_rdy=%b, required vld=1 d=%h mask=%b byte_rdy=0",
                              c, bus32.msg_inpt_vld, bus32.msg_inpt_d, bus32.msg_inpt_vld_byte, bus32.byte_rdy,
                              exp_d[0], exp_m[0]);
                  end
               end
            end
            @(posedge clk); #1;
            bus32.msg_inpt_rdy = 1'b1;
         end
      join
      drain_and_compare(1'b0, "backpressure");
   endtask

   task automatic test_dw64();
      clear_sb();
      msg_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      model_msg(8);
      exp_msg[1]++;
      send(1'b1, 0, 5, 1'b1, 0);
      drain_and_compare(1'b1, "dw64");
      n_cmp++;
      if ({obs_d[0], obs_m[0]} !== {64'h0102_0304_0500_0000, 8'b1111_1000}) begin
         n_err++;
         $display("FAIL dw64_literal: got d=%h mask=%b, required d=0102030405000000 mask=11111000", obs_d[0], obs_m[0]);
      end
   endtask

   task automatic test_back_to_back();
      int len;
      clear_sb();
      msg_bytes = '{8'hAB};
      model_msg(4);
      exp_msg[0]++;
      send(1'b0, 0, 1, 1'b1, 0);
      msg_bytes.delete();
      len = int'($urandom_range(2, 9));
      for (int i = 0; i < len; i++) msg_bytes.push_back(8'($urandom));
      model_msg(4);
      exp_msg[0]++;
      send(1'b0, 0, len, 1'b1, 0);
      drain_and_compare(1'b0, "back_to_back");
      n_cmp++;
      if ({obs_d[0], obs_m[0], obs_l[0]} !== {64'h0000_0000_AB00_0000, 8'b0000_1000, 1'b1}) begin
         n_err++;
         $display("FAIL single_byte: got d=%h mask=%b lst=%b, required d=ab000000 mask=1000 lst=1",
                  obs_d[0], obs_m[0], obs_l[0]);
      end
   endtask

   task automatic test_reset_mid();
      clear_sb();
      msg_bytes.delete();
      for (int i = 0; i < 6; i++) msg_bytes.push_back(8'($urandom));
      bus32.msg_inpt_rdy = 1'b0;
      send(1'b0, 0, 6, 1'b0, 0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus32.byte_rdy, bus32.msg_inpt_vld, bus32.msg_inpt_lst, bus32.msg_inpt_vld_byte, bus32.msg_inpt_d} !== '0) begin
         n_err++;
         $display("FAIL midreset_out32: got rdy=%b vld=%b lst=%b mask=%b d=%h, required all 0", bus32.byte_rdy,
                  bus32.msg_inpt_vld, bus32.msg_inpt_lst, bus32.msg_inpt_vld_byte, bus32.msg_inpt_d);
      end
      n_cmp++;
      if ({byte_cnt32, msg_cnt32} !== '0) begin
         n_err++;
         $display("FAIL midreset_cnt: got byte_cnt=%0d msg_cnt=%0d, required 0 0", byte_cnt32, msg_cnt32);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_msg[0] = 0;
      exp_msg[1] = 0;
      bus32.msg_inpt_rdy = 1'b1;
      clear_sb();
      msg_bytes.delete();
      for (int i = 0; i < 4; i++) msg_bytes.push_back(8'($urandom));
      model_msg(4);
      exp_msg[0]++;
      send(1'b0, 0, 3, 1'b0, 0);
      n_cmp++;
      if (byte_cnt32 !== 61'd3) begin
         n_err++;
         $display("FAIL midreset_restart sts_byte_cnt: got %0d, required 3", byte_cnt32);
      end
      send(1'b0, 3, 4, 1'b1, 0);
      drain_and_compare(1'b0, "after_reset");
   endtask

   task automatic test_random();
      bit w64;
      int len;
      rdy_rand = 1'b1;
      for (int k = 0; k < 16; k++) begin
         clear_sb();
         w64 = 1'($urandom_range(0, 1));
         len = int'($urandom_range(1, 20));
         msg_bytes.delete();
         for (int i = 0; i < len; i++) msg_bytes.push_back(8'($urandom));
         model_msg(w64 ? 8 : 4);
         exp_msg[w64]++;
         send(w64, 0, len, 1'b1, 2);
         drain_and_compare(w64, $sformatf("random%0d", k));
      end
      rdy_rand = 1'b0;
      @(posedge clk); #2;
      bus32.msg_inpt_rdy = 1'b1;
      bus64.msg_inpt_rdy = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_abc();
      test_64_bytes();
      test_backpressure();
      test_dw64();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
